// File: rtl/mux_arb_reg_if.sv
`timescale 1ns/1ps
`default_nettype none
// ---- mux_arb_reg_if : valid/ready bus between N producers and one registered consumer ----
// ---- rev 1.0                                                                           ----
interface mux_arb_reg_if #(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 4,
  parameter int CH_W   = $clog2(NUM_CH)
);
  logic [CH_W-1:0]          sel;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_ready;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic [CH_W-1:0]          out_ch;
  logic                     out_ready;

  modport master (
    output sel, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );

  modport slave (
    input  sel, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );
endinterface
`default_nettype wire

// File: rtl/mux_arb_reg.sv
`timescale 1ns/1ps
`default_nettype none
// ---- mux_arb_reg : N-channel registered mux, round-robin or sel-addressed, valid/ready ----
// ---- rev 1.0                                                                          ----
module mux_arb_reg #(
  parameter int NUM_CH  = 8,
  parameter int DATA_W  = 4,
  parameter int RR_MODE = 1
) (
  input  logic          clk,
  input  logic          rst,
  mux_arb_reg_if.slave  bus
);
  localparam int CH_W = $clog2(NUM_CH);

  logic              w_load_en;
  logic              w_gnt_vld;
  logic [CH_W-1:0]   w_gnt_ch;
  logic              w_xfer;

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [CH_W-1:0]   r_out_ch;

  // The output register may accept a new beat when empty or being drained this cycle.
  assign w_load_en = !r_out_valid || bus.out_ready;
  assign w_xfer    = !rst && w_load_en && w_gnt_vld;

  generate
    if (RR_MODE != 0) begin : g_rr
      logic [CH_W-1:0] r_last;
      logic [CH_W-1:0] w_idx;

      // Scan from farthest to nearest so the channel right after r_last wins.
      always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_ch  = '0;
        w_idx     = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
          w_idx = CH_W'((int'(r_last) + i) % NUM_CH);
          if (bus.in_valid[w_idx]) begin
            w_gnt_vld = 1'b1;
            w_gnt_ch  = w_idx;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          r_last <= CH_W'(NUM_CH - 1);
        end else if (w_xfer) begin
          r_last <= w_gnt_ch;
        end
      end
    end else begin : g_fixed
      logic w_sel_in_range;

      assign w_sel_in_range = ({1'b0, bus.sel} < (CH_W + 1)'(NUM_CH));
      assign w_gnt_vld      = w_sel_in_range && bus.in_valid[bus.sel];
      assign w_gnt_ch       = bus.sel;
    end
  endgenerate

  always_comb begin
    bus.in_ready = '0;
    if (w_xfer) begin
      bus.in_ready[w_gnt_ch] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= bus.in_data[int'(w_gnt_ch) * DATA_W +: DATA_W];
      r_out_ch    <= w_gnt_ch;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_ch    = r_out_ch;
endmodule
`default_nettype wire

// File: tb/tb_mux_arb_reg.sv
`timescale 1ns/1ps
`default_nettype none
// ---- tb_mux_arb_reg : directed bench, round-robin and fixed-select instances side by side ----
// ---- rev 1.0                                                                              ----
module tb_mux_arb_reg;
  localparam int NUM_CH = 8;
  localparam int DATA_W = 4;
  localparam int CH_W   = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [CH_W-1:0]          tv_sel;
  logic [NUM_CH-1:0]        tv_valid;
  logic [NUM_CH*DATA_W-1:0] tv_data;
  logic                     tv_ordy;

  mux_arb_reg_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) rr_if ();
  mux_arb_reg_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) fx_if ();

  assign rr_if.sel       = tv_sel;
  assign rr_if.in_valid  = tv_valid;
  assign rr_if.in_data   = tv_data;
  assign rr_if.out_ready = tv_ordy;
  assign fx_if.sel       = tv_sel;
  assign fx_if.in_valid  = tv_valid;
  assign fx_if.in_data   = tv_data;
  assign fx_if.out_ready = tv_ordy;

  mux_arb_reg #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .RR_MODE(1)) u_rr (
    .clk (clk),
    .rst (rst),
    .bus (rr_if.slave)
  );

  mux_arb_reg #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .RR_MODE(0)) u_fx (
    .clk (clk),
    .rst (rst),
    .bus (fx_if.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: index 0 = round-robin instance, 1 = fixed-select instance.
  int m_valid[2];
  int m_data[2];
  int m_ch[2];
  int m_last[2];
  bit m_live = 1'b0;

  function automatic int pick(input int d, input int last);
    if (d == 0) begin
      for (int i = 1; i <= NUM_CH; i++) begin
        int k;
        k = (last + i) % NUM_CH;
        if (tv_valid[k]) return k;
      end
      return -1;
    end
    if (int'(tv_sel) < NUM_CH && tv_valid[tv_sel]) return int'(tv_sel);
    return -1;
  endfunction

  function automatic int exp_ready(input int d);
    int g;
    if (rst) return 0;
    if (m_valid[d] != 0 && !tv_ordy) return 0;
    g = pick(d, m_last[d]);
    if (g < 0) return 0;
    return 1 << g;
  endfunction

  always @(posedge clk) begin : mdl
    int g;
    bit le;
    for (int d = 0; d < 2; d++) begin
      g  = pick(d, m_last[d]);
      le = (m_valid[d] == 0) || tv_ordy;
      if (rst) begin
        m_valid[d] = 0;
        m_data[d]  = 0;
        m_ch[d]    = 0;
        m_last[d]  = NUM_CH - 1;
      end else if (le && g >= 0) begin
        m_valid[d] = 1;
        m_data[d]  = int'(tv_data[g*DATA_W +: DATA_W]);
        m_ch[d]    = g;
        if (d == 0) m_last[d] = g;
      end else if (tv_ordy) begin
        m_valid[d] = 0;
      end
    end
    m_live = 1'b1;
  end

  task automatic cmp(input string tag, input int d, input logic ov, input logic [DATA_W-1:0] od,
                     input logic [CH_W-1:0] oc, input logic [NUM_CH-1:0] ir);
    chk({tag, "_out_valid"}, int'(ov), m_valid[d]);
    chk({tag, "_out_data"}, int'(od), m_data[d]);
    chk({tag, "_out_ch"}, int'(oc), m_ch[d]);
    chk({tag, "_in_ready"}, int'(ir), exp_ready(d));
    chk({tag, "_onehot"}, int'($countones(ir) <= 1), 1);
  endtask

  always @(negedge clk) begin
    if (m_live) begin
      cmp("rr", 0, rr_if.out_valid, rr_if.out_data, rr_if.out_ch, rr_if.in_ready);
      cmp("fx", 1, fx_if.out_valid, fx_if.out_data, fx_if.out_ch, fx_if.in_ready);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int base);
    for (int k = 0; k < NUM_CH; k++) tv_data[k*DATA_W +: DATA_W] = DATA_W'(base + k);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    tv_valid = '1;
    tv_sel   = '0;
    tv_ordy  = 1'b1;
    set_data(1);
    step();
    step();
    chk("rst_out_valid", int'(rr_if.out_valid), 0);
    chk("rst_out_data", int'(rr_if.out_data), 0);
    chk("rst_out_ch", int'(rr_if.out_ch), 0);
    chk("rst_in_ready_rr", int'(rr_if.in_ready), 0);
    chk("rst_in_ready_fx", int'(fx_if.in_ready), 0);
    rst = 1'b0;

    // Fixed select: sel steps 0..7, data k+1; round-robin runs 0..7 alongside.
    for (int s = 0; s < NUM_CH; s++) begin
      tv_sel = CH_W'(s);
      step();
      chk("fix_data", int'(fx_if.out_data), s + 1);
      chk("fix_ch", int'(fx_if.out_ch), s);
      chk("rr_first_ch", int'(rr_if.out_ch), s);
    end

    // Full round robin with data A+k.
    set_data(10);
    for (int i = 0; i < NUM_CH + 1; i++) begin
      step();
      chk("rr_ch", int'(rr_if.out_ch), i % NUM_CH);
      chk("rr_data", int'(rr_if.out_data), (10 + i % NUM_CH) % 16);
      chk("rr_valid", int'(rr_if.out_valid), 1);
      chk("rr_one_ready", $countones(rr_if.in_ready), 1);
    end

    // Sparse: channels 1 and 7 alternate, wrapping 7 -> 1.
    tv_valid = 8'b1000_0010;
    step();
    chk("sparse_ch_a", int'(rr_if.out_ch), 1);
    chk("sparse_data_a", int'(rr_if.out_data), 11);
    step();
    chk("sparse_ch_b", int'(rr_if.out_ch), 7);
    chk("sparse_data_b", int'(rr_if.out_data), 1);
    step();
    chk("sparse_ch_c", int'(rr_if.out_ch), 1);

    // Backpressure after a beat of 5 from ch2.
    tv_valid = 8'b0000_0100;
    tv_data[2*DATA_W +: DATA_W] = 4'h5;
    tv_sel = 3'd2;
    step();
    chk("bp_load_data", int'(rr_if.out_data), 5);
    chk("bp_load_ch", int'(rr_if.out_ch), 2);
    chk("bp_fx_ch", int'(fx_if.out_ch), 2);
    tv_valid = '1;
    tv_ordy  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_valid", int'(rr_if.out_valid), 1);
      chk("bp_data", int'(rr_if.out_data), 5);
      chk("bp_ch", int'(rr_if.out_ch), 2);
      chk("bp_in_ready", int'(rr_if.in_ready), 0);
      chk("bp_fx_in_ready", int'(fx_if.in_ready), 0);
    end
    tv_ordy = 1'b1;
    #1;
    chk("bp_release_ready_rr", int'(rr_if.in_ready), 8'h08);
    chk("bp_release_ready_fx", int'(fx_if.in_ready), 8'h04);
    step();
    chk("bp_nobubble_valid", int'(rr_if.out_valid), 1);
    chk("bp_nobubble_ch", int'(rr_if.out_ch), 3);
    chk("bp_nobubble_data", int'(rr_if.out_data), 13);

    // Reset while a beat is held.
    tv_ordy = 1'b0;
    step();
    chk("mid_held_valid", int'(rr_if.out_valid), 1);
    rst = 1'b1;
    step();
    chk("mid_rst_valid", int'(rr_if.out_valid), 0);
    chk("mid_rst_fx_valid", int'(fx_if.out_valid), 0);
    rst = 1'b0;
    tv_ordy = 1'b1;
    step();
    chk("mid_next_ch", int'(rr_if.out_ch), 0);
    chk("mid_next_data", int'(rr_if.out_data), 10);
    chk("mid_fx_data", int'(fx_if.out_data), 5);

    tv_valid = '0;
    step();
    chk("idle_drain_valid", int'(rr_if.out_valid), 0);
    chk("idle_hold_ch", int'(rr_if.out_ch), 0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
